// File: rtl/hazard_stall_ctrl.sv
// RAW-hazard stall controller with shadow E/M destination tracking and MDU busy counter.
// Optional STALL_PERF_CNT_EN adds a free-running count of stalled cycles (stall_cycles).
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  input  logic [1:0]  D_Tuse1,
  input  logic [1:0]  D_Tuse2,
  input  logic [4:0]  D_A3,
  input  logic [1:0]  D_Tnew,
  input  logic        D_is_md,
  input  logic        E_start,
  input  logic        E_is_div,
  input  logic        flush,
  output logic        stall,
  output logic        mdu_busy,
  output logic [4:0]  E_A3,
  output logic [4:0]  M_A3
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
  } shadow_t;

  localparam shadow_t BUBBLE = '{a3: 5'd0, tnew: 2'd0};

  shadow_t          e_q, e_d, m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_rs, stall_rt, stall_md;

  // A source stalls only if it is needed before the matching producer can forward it.
  always_comb begin
    stall_rs = (D_A1 != 5'd0) &&
               (((D_Tuse1 < e_q.tnew) && (D_A1 == e_q.a3)) ||
                ((D_Tuse1 < m_q.tnew) && (D_A1 == m_q.a3)));
    stall_rt = (D_A2 != 5'd0) &&
               (((D_Tuse2 < e_q.tnew) && (D_A2 == e_q.a3)) ||
                ((D_Tuse2 < m_q.tnew) && (D_A2 == m_q.a3)));
    stall_md = D_is_md && ((cnt_q != '0) || E_start);
  end

  // Outputs are forced low while reset is held so stall drops without a clock edge.
  assign stall    = reset & (stall_rs | stall_rt | stall_md);
  assign mdu_busy = reset & ((cnt_q != '0) | E_start);
  assign E_A3     = e_q.a3;
  assign M_A3     = m_q.a3;

  always_comb begin
    e_d = BUBBLE;
    m_d = BUBBLE;
    if (!flush) begin
      m_d.a3   = e_q.a3;
      m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
      if (!stall) e_d = '{a3: D_A3, tnew: D_Tnew};
    end
  end

  // Counter is unaffected by flush: an issued mult/div always runs to completion.
  always_comb begin
    cnt_d = cnt_q;
    if (E_start)             cnt_d = E_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q   <= BUBBLE;
      m_q   <= BUBBLE;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     stall_cycles_q <= '0;
    else if (stall) stall_cycles_q <= stall_cycles_q + 32'd1;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; expected outputs queued per step and checked at negedge.
module tb_hazard_stall_ctrl;

  logic       clk, reset;
  logic [4:0] D_A1, D_A2, D_A3;
  logic [1:0] D_Tuse1, D_Tuse2, D_Tnew;
  logic       D_is_md, E_start, E_is_div, flush;
  logic       stall, mdu_busy;
  logic [4:0] E_A3, M_A3;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .D_A1(D_A1), .D_A2(D_A2), .D_Tuse1(D_Tuse1), .D_Tuse2(D_Tuse2),
    .D_A3(D_A3), .D_Tnew(D_Tnew), .D_is_md(D_is_md),
    .E_start(E_start), .E_is_div(E_is_div), .flush(flush),
    .stall(stall), .mdu_busy(mdu_busy), .E_A3(E_A3), .M_A3(M_A3)
`ifdef STALL_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       stall;
    logic       busy;
    logic [4:0] e;
    logic [4:0] m;
  } obs_t;

  obs_t exp_q[$];
  int   ntests = 0;
  int   nfail  = 0;

  task automatic push(input logic s, input logic b, input logic [4:0] e, input logic [4:0] m);
    obs_t x;
    x.stall = s; x.busy = b; x.e = e; x.m = m;
    exp_q.push_back(x);
  endtask

  task automatic check(input string tag);
    obs_t x, o;
    x = exp_q.pop_front();
    o.stall = stall; o.busy = mdu_busy; o.e = E_A3; o.m = M_A3;
    ntests++;
    assert (o === x) else begin
      nfail++;
      $error("FAIL %s: got stall=%b busy=%b E_A3=%0d M_A3=%0d, want stall=%b busy=%b E_A3=%0d M_A3=%0d",
             tag, o.stall, o.busy, o.e, o.m, x.stall, x.busy, x.e, x.m);
    end
  endtask

  // One pipeline cycle: queue expectation, sample at negedge, advance to just after the next posedge.
  task automatic cyc(input string tag, input logic s, input logic b, input logic [4:0] e, input logic [4:0] m);
    push(s, b, e, m);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic drv_d(input logic [4:0] a1, input logic [1:0] u1, input logic [4:0] a2,
                       input logic [1:0] u2, input logic [4:0] a3, input logic [1:0] tn);
    D_A1 = a1; D_Tuse1 = u1; D_A2 = a2; D_Tuse2 = u2; D_A3 = a3; D_Tnew = tn;
  endtask

  initial begin
    reset = 1'b0;
    drv_d(0, 3, 0, 3, 0, 0);
    D_is_md = 0; E_start = 0; E_is_div = 0; flush = 0;
    #2;
    cyc("reset_state", 0, 0, 0, 0);
    reset = 1'b1;
    #1;

    // Load-use where the consumer needs the value in D (Tuse 0): stalls in E and again in M.
    drv_d(0, 3, 0, 3, 8, 2);
    cyc("lw_issue", 0, 0, 0, 0);
    drv_d(8, 0, 0, 3, 9, 1);
    cyc("lw_use_E", 1, 0, 8, 0);
    cyc("lw_use_M", 1, 0, 0, 8);
    cyc("lw_use_done", 0, 0, 0, 0);

    // $0 and unused-operand cases.
    drv_d(0, 0, 0, 3, 9, 2);
    cyc("zero_reg_a", 0, 0, 9, 0);
    drv_d(0, 0, 9, 3, 0, 0);
    cyc("tuse3_rt", 0, 0, 9, 9);
    drv_d(0, 0, 0, 3, 0, 0);
    cyc("zero_reg_b", 0, 0, 0, 9);
    cyc("idle_a", 0, 0, 0, 0);

    // ALU result consumed by a branch in D: one stall cycle, then forward from M.
    drv_d(0, 3, 0, 3, 5, 1);
    cyc("addu_issue", 0, 0, 0, 0);
    drv_d(5, 0, 0, 0, 0, 0);
    cyc("beq_stall", 1, 0, 5, 0);
    cyc("beq_fwd_M", 0, 0, 0, 5);
    drv_d(0, 3, 0, 3, 0, 0);
    cyc("idle_b", 0, 0, 0, 0);

    // div followed immediately by mflo: 11 stall cycles.
    E_start = 1; E_is_div = 1; D_is_md = 1;
    cyc("div_start", 1, 1, 0, 0);
    E_start = 0; E_is_div = 0;
    for (int i = 10; i >= 1; i--) cyc($sformatf("div_cnt%0d", i), 1, 1, 0, 0);
    cyc("div_done", 0, 0, 0, 0);
    D_is_md = 0;

    // Flush during a load-use stall while a mult is counting down.
    E_start = 1;
    drv_d(0, 3, 0, 3, 8, 2);
    cyc("mul_lw", 0, 1, 0, 0);
    E_start = 0;
    drv_d(8, 0, 0, 3, 0, 0);
    cyc("mul_stall_E", 1, 1, 8, 0);
    flush = 1;
    cyc("flush_cnt4", 1, 1, 0, 8);
    flush = 0; D_is_md = 1;
    cyc("post_flush_cnt3", 1, 1, 0, 0);
    drv_d(0, 3, 0, 3, 0, 0);
    cyc("cnt2", 1, 1, 0, 0);
    cyc("cnt1", 1, 1, 0, 0);
    cyc("cnt0", 0, 0, 0, 0);
    D_is_md = 0;

    // Flush beats a valid D instruction entering E.
    drv_d(0, 3, 0, 3, 7, 1);
    flush = 1;
    cyc("flush_D", 0, 0, 0, 0);
    flush = 0;
    drv_d(0, 3, 0, 3, 0, 0);
    cyc("flush_D_after", 0, 0, 0, 0);

    // Asynchronous reset mid-div with cnt=6.
    E_start = 1; E_is_div = 1;
    drv_d(0, 3, 0, 3, 3, 1);
    cyc("rdiv_start", 0, 1, 0, 0);
    E_start = 0; E_is_div = 0;
    drv_d(0, 3, 0, 3, 4, 2);
    cyc("rdiv_c10", 0, 1, 3, 0);
    cyc("rdiv_c9", 0, 1, 4, 3);
    cyc("rdiv_c8", 0, 1, 4, 4);
    cyc("rdiv_c7", 0, 1, 4, 4);
    D_is_md = 1;
    drv_d(4, 0, 0, 3, 0, 0);
    push(1, 1, 4, 4);
    @(negedge clk);
    check("rdiv_c6");
    #2;
    reset = 1'b0;
    #1;
    push(0, 0, 0, 0);
    check("async_reset");
`ifdef STALL_PERF_CNT_EN
    ntests++;
    assert (stall_cycles === 32'd0) else begin
      nfail++;
      $error("FAIL perf_reset: got stall_cycles=%0d, want 0", stall_cycles);
    end
`endif
    #10;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
